// File: rtl/sent_tx_frame.sv
// sent_tx_frame: SENT fast-channel frame transmitter; frame handshake in, CRC4 stage feed/collect, tick-timed SENT line out
module sent_tx_frame #(
  parameter int TICK_DIV     = 30,
  parameter int DATA_NIBBLES = 6,
  parameter int LOW_TICKS    = 5,
  parameter int PAUSE_EN     = 0,
  parameter int PAUSE_TICKS  = 77
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [3:0]                frame_status,
  input  logic [4*DATA_NIBBLES-1:0] frame_data,
  output logic                      crc_init,
  output logic                      crc_en,
  output logic [3:0]                crc_din,
  input  logic [3:0]                crc_dout,
  output logic                      sent_out,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int NW = 4 * DATA_NIBBLES;
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [9:0] LOW = 10'(LOW_TICKS);
  localparam logic [9:0] LOAD_LAST = 10'(DATA_NIBBLES + 1);
  localparam logic [9:0] EN_LAST = 10'(DATA_NIBBLES);
  localparam logic [9:0] PAUSE_LEN = 10'(PAUSE_TICKS);
  localparam logic [2:0] IDX_LAST = 3'(DATA_NIBBLES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, SYNC, STATUS, DATA, CRCN, PAUSE, CLOSE} state_t;
  state_t state_q, state_d;
  logic [9:0] cnt_q, cnt_d, len;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] status_q, status_d, crc_q, crc_d, nib, ld_nib, din_q, din_d;
  logic [NW-1:0] data_q, data_d;
  logic tick, sym_end;
  logic ready_q, ready_d, busy_q, busy_d, init_q, init_d, en_q, en_d, sent_q, sent_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    div_d = div_q;
    idx_d = idx_q;
    status_d = status_q;
    data_d = data_q;
    crc_d = crc_q;
    tick = div_q == DIV_LAST;
    nib = 4'(data_q >> (4 * idx_q));
    len = state_q == SYNC ? 10'd56 :
          state_q == STATUS ? 10'd12 + 10'(status_q) :
          state_q == DATA ? 10'd12 + 10'(nib) :
          state_q == CRCN ? 10'd12 + 10'(crc_q) : PAUSE_LEN;
    sym_end = tick && cnt_q == len - 10'd1;
    if (state_q inside {SYNC, STATUS, DATA, CRCN, PAUSE, CLOSE}) begin
      div_d = tick ? '0 : div_q + 1'b1;
      cnt_d = cnt_q + 10'(tick);
    end
    case (state_q)
      IDLE: if (frame_valid && ready_q) begin
        state_d = LOAD;
        cnt_d = '0;
        status_d = frame_status;
        data_d = frame_data;
      end
      LOAD: begin
        cnt_d = cnt_q + 10'd1;
        if (cnt_q == LOAD_LAST) begin
          state_d = SYNC;
          cnt_d = '0;
          div_d = '0;
          crc_d = crc_dout;
        end
      end
      SYNC: if (sym_end) begin
        state_d = STATUS;
        cnt_d = '0;
      end
      STATUS: if (sym_end) begin
        state_d = DATA;
        cnt_d = '0;
        idx_d = '0;
      end
      DATA: if (sym_end) begin
        cnt_d = '0;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == IDX_LAST ? CRCN : DATA;
      end
      CRCN: if (sym_end) begin
        cnt_d = '0;
        state_d = PAUSE_EN != 0 ? PAUSE : CLOSE;
      end
      PAUSE: if (sym_end) begin
        cnt_d = '0;
        state_d = CLOSE;
      end
      CLOSE: if (cnt_q == LOW) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ld_nib = 4'(data_d >> (4 * (cnt_d[2:0] - 3'd1)));
    ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    init_d = state_d == LOAD && cnt_d == '0;
    en_d = state_d == LOAD && cnt_d != '0 && cnt_d <= EN_LAST;
    din_d = en_d ? ld_nib : 4'h0;
    done_d = state_d == CLOSE && cnt_d == LOW;
    sent_d = state_d inside {IDLE, LOAD} || cnt_d >= LOW;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      div_q <= '0;
      idx_q <= '0;
      status_q <= '0;
      data_q <= '0;
      crc_q <= '0;
      ready_q <= 1'b1;
      busy_q <= 1'b0;
      init_q <= 1'b0;
      en_q <= 1'b0;
      din_q <= '0;
      sent_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      idx_q <= idx_d;
      status_q <= status_d;
      data_q <= data_d;
      crc_q <= crc_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      init_q <= init_d;
      en_q <= en_d;
      din_q <= din_d;
      sent_q <= sent_d;
      done_q <= done_d;
    end
  end
  assign frame_ready = ready_q;
  assign busy = busy_q;
  assign crc_init = init_q;
  assign crc_en = en_q;
  assign crc_din = din_q;
  assign sent_out = sent_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_sent_tx_frame.sv
// tb_sent_tx_frame: randomized frame-level checks of sent_tx_frame (with and without pause) against a symbol-list reference model
module tb_sent_tx_frame;
  localparam int TD = 2, N = 6, LOW = 5, PT = 20;
  localparam logic [9:0] IDLE_V = 10'b1000000001;
  logic clk = 0, reset = 1, valid_a = 0, valid_p = 0, crc_force = 0;
  logic [3:0] st = 0, nxt_st = 0;
  logic [23:0] dat = 0, nxt_dat = 0;
  logic ready_a, init_a, en_a, sent_a, busy_a, done_a;
  logic ready_p, init_p, en_p, sent_p, busy_p, done_p;
  logic [3:0] din_a, din_p, stub_a, stub_p, dout_a, dout_p;
  int n_cmp = 0, n_bad = 0;
  logic [9:0] exp_q[$], act_q[$];
  bit acc_ok;
  always #5 clk = ~clk;
  always_ff @(posedge clk) stub_a <= init_a ? 4'h5 : en_a ? {stub_a[2:0], stub_a[3]} ^ din_a : stub_a;
  always_ff @(posedge clk) stub_p <= init_p ? 4'h5 : en_p ? {stub_p[2:0], stub_p[3]} ^ din_p : stub_p;
  assign dout_a = crc_force ? 4'hA : stub_a;
  assign dout_p = crc_force ? 4'hA : stub_p;
  sent_tx_frame #(.TICK_DIV(TD), .DATA_NIBBLES(N), .LOW_TICKS(LOW), .PAUSE_EN(0), .PAUSE_TICKS(PT)) dut (
    .clk(clk), .reset(reset), .frame_valid(valid_a), .frame_ready(ready_a), .frame_status(st),
    .frame_data(dat), .crc_init(init_a), .crc_en(en_a), .crc_din(din_a), .crc_dout(dout_a),
    .sent_out(sent_a), .busy(busy_a), .frame_done(done_a));
  sent_tx_frame #(.TICK_DIV(TD), .DATA_NIBBLES(N), .LOW_TICKS(LOW), .PAUSE_EN(1), .PAUSE_TICKS(PT)) dut_p (
    .clk(clk), .reset(reset), .frame_valid(valid_p), .frame_ready(ready_p), .frame_status(st),
    .frame_data(dat), .crc_init(init_p), .crc_en(en_p), .crc_din(din_p), .crc_dout(dout_p),
    .sent_out(sent_p), .busy(busy_p), .frame_done(done_p));
  function automatic logic [9:0] obs(input int inst);
    return inst == 0 ? {ready_a, busy_a, done_a, init_a, en_a, din_a, sent_a}
                     : {ready_p, busy_p, done_p, init_p, en_p, din_p, sent_p};
  endfunction
  function automatic logic [3:0] crc_model(input logic [23:0] d);
    logic [3:0] c = 4'h5;
    for (int i = 0; i < N; i++) c = {c[2:0], c[3]} ^ d[4*i +: 4];
    return c;
  endfunction
  task automatic build_exp(input bit pause, input logic [3:0] s, input logic [23:0] d, input logic [3:0] crc);
    int lens[$];
    bit en;
    logic [3:0] din;
    exp_q.delete();
    for (int t = 1; t <= N + 2; t++) begin
      en = t >= 2 && t <= N + 1;
      din = en ? d[4*(t-2) +: 4] : 4'h0;
      exp_q.push_back({1'b0, 1'b1, 1'b0, 1'(t == 1), en, din, 1'b1});
    end
    lens.push_back(56);
    lens.push_back(12 + int'(s));
    for (int i = 0; i < N; i++) lens.push_back(12 + int'(d[4*i +: 4]));
    lens.push_back(12 + int'(crc));
    if (pause) lens.push_back(PT);
    foreach (lens[i])
      for (int c = 0; c < lens[i] * TD; c++) exp_q.push_back({5'b01000, 4'h0, 1'(c >= LOW * TD)});
    for (int c = 0; c < LOW * TD; c++) exp_q.push_back({5'b01000, 4'h0, 1'b0});
    exp_q.push_back({5'b01100, 4'h0, 1'b1});
  endtask
  task automatic offer(input int inst, input logic [3:0] s, input logic [23:0] d);
    st = s;
    dat = d;
    if (inst == 0) valid_a = 1; else valid_p = 1;
    acc_ok = 0;
    for (int i = 0; i < 2000 && !acc_ok; i++) begin
      @(negedge clk);
      acc_ok = inst == 0 ? ready_a : ready_p;
    end
  endtask
  task automatic capture(input int inst, input int n, input bit hold);
    act_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0 && hold) begin
        st = nxt_st;
        dat = nxt_dat;
      end else if (i == 0) begin
        valid_a = 0;
        valid_p = 0;
      end
      act_q.push_back(obs(inst));
    end
  endtask
  function automatic int first_diff();
    foreach (act_q[i]) if (act_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs(0) !== IDLE_V) begin n_bad++; $display("FAIL reset_a: got %b want %b", obs(0), IDLE_V); end
    n_cmp++;
    if (obs(1) !== IDLE_V) begin n_bad++; $display("FAIL reset_p: got %b want %b", obs(1), IDLE_V); end
    reset = 0;
  endtask
  task automatic test_frame(input string name, input int inst, input logic [3:0] s, input logic [23:0] d);
    int fd;
    offer(inst, s, d);
    n_cmp++;
    if (!acc_ok) begin n_bad++; $display("FAIL %s_accept: ready got 0 want 1 within 2000 cycles", name); end
    build_exp(inst == 1, s, d, crc_force ? 4'hA : crc_model(d));
    capture(inst, exp_q.size(), 0);
    fd = first_diff();
    n_cmp++;
    if (fd >= 0) begin n_bad++; $display("FAIL %s_trace: cycle %0d got %b want %b", name, fd + 1, act_q[fd], exp_q[fd]); end
    @(negedge clk);
    n_cmp++;
    if (obs(inst) !== IDLE_V) begin n_bad++; $display("FAIL %s_idle: got %b want %b", name, obs(inst), IDLE_V); end
  endtask
  task automatic test_patterns();
    test_frame("zero", 0, 4'h0, 24'h000000);
    test_frame("ones", 0, 4'hF, 24'hFFFFFF);
    crc_force = 1;
    test_frame("crc_stub", 0, 4'($urandom), 24'($urandom));
    crc_force = 0;
  endtask
  task automatic test_pause();
    test_frame("pause", 1, 4'($urandom), 24'($urandom));
    test_frame("pause_ones", 1, 4'hF, 24'hFFFFFF);
  endtask
  task automatic test_random();
    for (int i = 0; i < 4; i++) test_frame("random", i % 2, 4'($urandom), 24'($urandom));
  endtask
  task automatic test_back_to_back();
    int fd;
    logic [3:0] s1 = 4'($urandom);
    logic [23:0] d1 = 24'($urandom);
    nxt_st = 4'($urandom);
    nxt_dat = 24'($urandom);
    offer(0, s1, d1);
    n_cmp++;
    if (!acc_ok) begin n_bad++; $display("FAIL b2b_accept: ready got 0 want 1 within 2000 cycles"); end
    build_exp(0, s1, d1, crc_model(d1));
    capture(0, exp_q.size(), 1);
    fd = first_diff();
    n_cmp++;
    if (fd >= 0) begin n_bad++; $display("FAIL b2b_first: cycle %0d got %b want %b", fd + 1, act_q[fd], exp_q[fd]); end
    @(negedge clk);
    n_cmp++;
    if (obs(0) !== IDLE_V) begin n_bad++; $display("FAIL b2b_gap: got %b want %b", obs(0), IDLE_V); end
    build_exp(0, nxt_st, nxt_dat, crc_model(nxt_dat));
    capture(0, exp_q.size(), 0);
    fd = first_diff();
    n_cmp++;
    if (fd >= 0) begin n_bad++; $display("FAIL b2b_second: cycle %0d got %b want %b", fd + 1, act_q[fd], exp_q[fd]); end
    @(negedge clk);
    n_cmp++;
    if (obs(0) !== IDLE_V) begin n_bad++; $display("FAIL b2b_idle: got %b want %b", obs(0), IDLE_V); end
  endtask
  task automatic test_reset_mid();
    int fd, k;
    bit seen_done = 0;
    logic [3:0] s = 4'($urandom);
    logic [23:0] d = 24'($urandom);
    offer(0, s, d);
    build_exp(0, s, d, crc_model(d));
    k = N + 2 + 56 * TD + (12 + int'(s)) * TD + (12 + int'(d[3:0])) * TD + (12 + int'(d[7:4])) * TD + 1;
    capture(0, k, 0);
    fd = first_diff();
    n_cmp++;
    if (fd >= 0) begin n_bad++; $display("FAIL rst_mid_prefix: cycle %0d got %b want %b", fd + 1, act_q[fd], exp_q[fd]); end
    n_cmp++;
    if (sent_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_low: sent_out got %b want 0", sent_a); end
    reset = 1;
    @(negedge clk);
    n_cmp++;
    if (obs(0) !== IDLE_V) begin n_bad++; $display("FAIL rst_mid_state: got %b want %b", obs(0), IDLE_V); end
    reset = 0;
    repeat (300) begin
      @(negedge clk);
      seen_done |= done_a;
    end
    n_cmp++;
    if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: frame_done seen %b want 0", seen_done); end
    test_frame("after_reset", 0, 4'($urandom), 24'($urandom));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_patterns();
    test_pause();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sent_tx_frame.md
Name: sent_tx_frame

Overview:
SENT fast-channel frame transmitter, directly upstream of the SENT CRC4 stage. Accepts one frame (status nibble plus DATA_NIBBLES data nibbles) over a valid/ready handshake. Streams the data nibbles into the CRC4 stage and collects its 4-bit result. Serialises sync, status, data, CRC, optional pause and closing pulse onto the single-wire SENT output with tick-accurate timing.

Parameters:
TICK_DIV, 30, clk cycles per SENT tick (>=1)
DATA_NIBBLES, 6, data nibbles per frame (1..6)
LOW_TICKS, 5, low-phase length of every pulse, in ticks (4..11)
PAUSE_EN, 0, 1 = insert pause pulse after the CRC nibble
PAUSE_TICKS, 77, pause pulse length in ticks (12..768); used only when PAUSE_EN=1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_valid  in  1  frame offered
frame_ready  out  1  block can accept a frame
frame_status  in  4  status/comm nibble
frame_data  in  4*DATA_NIBBLES  data nibbles; bits [3:0] are transmitted first
crc_init  out  1  one-cycle pulse; drives the CRC4 stage reset (seed load)
crc_en  out  1  CRC4 stage enable
crc_din  out  4  nibble presented to the CRC4 stage
crc_dout  in  4  CRC4 stage result (registered in that stage)
sent_out  out  1  SENT line; idles high
busy  out  1  high from frame accept until frame_done
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: sent_out=1, frame_ready=1, busy=0, frame_done=0, crc_init=0, crc_en=0, crc_din=0. State is IDLE.
- States: IDLE -> LOAD -> SYNC -> STATUS -> DATA -> CRCN -> [PAUSE] -> CLOSE -> IDLE.
- IDLE:
  - frame_ready=1.
  - On frame_valid && frame_ready, latch frame_status and frame_data, set busy=1, and go to LOAD next cycle.
- Outside IDLE:
  - frame_ready=0.
  - frame_valid is ignored.
- LOAD (DATA_NIBBLES+2 cycles, sent_out stays high):
  - Cycle 0: crc_init=1.
  - Cycles 1..N: crc_en=1, crc_din=data nibble k-1, in order nibble 0 first.
  - Cycle N+1: crc_en=0; capture crc_dout into crc_reg.
  - crc_din is held at 0 whenever crc_en=0.
- Tick divider:
  - Cleared on entry to SYNC; free-runs until CLOSE ends.
  - tick strobe asserts when the count reaches TICK_DIV-1, then the count wraps to 0.
- Symbol format:
  - Each symbol is L ticks = L*TICK_DIV clk cycles.
  - sent_out is low for the first LOW_TICKS ticks, then high for the remaining L-LOW_TICKS ticks.
  - The falling edge of sent_out occurs on the first cycle of the symbol.
- Symbol lengths:
  - SYNC: 56 ticks.
  - STATUS: 12+status.
  - DATA: 12+nibble, for N nibbles in order.
  - CRCN: 12+crc_reg.
  - PAUSE: PAUSE_TICKS; skipped when PAUSE_EN=0.
  - CLOSE: LOW_TICKS low, then one cycle high.
- Symbols are back-to-back, with no gap cycles between them.
- sent_out is registered (glitch-free).
- End of frame: on the last cycle of CLOSE, frame_done=1 for one cycle. The next cycle is IDLE with busy=0 and frame_ready=1.
- Back-to-back frames: a frame may be accepted on the first IDLE cycle after frame_done. Minimum inter-frame line gap is therefore LOAD duration plus 1 cycle.
- Counters: symbol tick counter 10 bits (max 768). Nibble index 3 bits.
- Reset mid-frame:
  - Next edge forces the reset values above.
  - No frame_done is generated.
  - Latched frame data is discarded.
  - crc_init is not pulsed by reset; the CRC4 stage is re-seeded at the next LOAD.

Test Plan:
- TICK_DIV=2, N=6, LOW=5, PAUSE_EN=0; status=0, data=0x000000 -> crc_din sequence 0,0,0,0,0,0 with crc_en high 6 consecutive cycles. sent_out: 10 low/102 high (sync), then seven 10 low/14 high symbols, then CRC symbol of (12+crc_model)*2 cycles, then 10 low and 1 high, then frame_done.
- data=0xFFFFFF, status=4'hF -> status and each data symbol is 54 cycles (10 low/44 high). crc_din presents 4'hF six times.
- Stub crc_dout=4'hA -> CRC symbol is 44 cycles, 10 low.
- PAUSE_EN=1, PAUSE_TICKS=20 -> 40-cycle pause symbol (10 low/30 high) between CRC and CLOSE.
- frame_valid held high with two frames queued -> second accept one cycle after frame_done. Second crc_init 1 cycle after that accept. frame_ready low during both frames.
- reset asserted during the 3rd data symbol while sent_out is low -> next cycle sent_out=1, busy=0, frame_ready=1. No frame_done. A new frame then transmits normally.
